// File: rtl/gl_imem_arbiter.sv
// Single-port instruction BRAM arbiter: host writes > operand bursts > fetch reads.
// Optional fetch starvation guard enabled by defining GL_IMEM_STARVE_GUARD_EN.
module gl_imem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          op_req,
  input  logic [AW-1:0] op_addr,
  input  logic [4:0]    op_len,
  output logic          op_gnt,
  output logic          op_rvalid,
  output logic          op_last,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  localparam logic [4:0] MAX_LEN = 5'(MAX_BURST);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [4:0]    len_q, len_d, cnt_q, cnt_d, len_eff;
  logic          f_tag_q, f_tag_d, op_tag_q, op_tag_d, last_q, last_d;
  logic [DW-1:0] rdata_q;
  logic          fetch_first, sel_op, sel_f;

`ifdef GL_IMEM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q;

  // saturating count of cycles fetch has waited without a grant
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (f_gnt) begin
      starve_q <= '0;
    end else if (f_req && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + SW'(1);
    end else begin
      starve_q <= starve_q;
    end
  end

  assign fetch_first = (starve_q == STARVE_MAX);
`else
  assign fetch_first = 1'b0;
`endif

  // clamp requested length into 1..MAX_BURST
  always_comb begin
    len_eff = op_len;
    if (op_len == 5'd0) begin
      len_eff = 5'd1;
    end else if (op_len > MAX_LEN) begin
      len_eff = MAX_LEN;
    end else begin
      len_eff = op_len;
    end
  end

  // host always wins; a starved fetch may jump ahead of the operand reader
  assign sel_op = !host_req && op_req && !(fetch_first && f_req);
  assign sel_f  = !host_req && f_req && !sel_op;

  // arbitration, BRAM port drive and next-state logic
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    f_tag_d   = 1'b0;
    op_tag_d  = 1'b0;
    last_d    = 1'b0;
    f_gnt     = 1'b0;
    op_gnt    = 1'b0;
    host_gnt  = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (!reset) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host_req) begin
            host_gnt  = 1'b1;
            bram_en   = 1'b1;
            bram_we   = 1'b1;
            bram_addr = host_addr;
            bram_din  = host_wdata;
          end else if (sel_op) begin
            op_gnt    = 1'b1;
            bram_en   = 1'b1;
            bram_addr = op_addr;
            op_tag_d  = 1'b1;
            base_d    = op_addr;
            len_d     = len_eff;
            if (len_eff == 5'd1) begin
              last_d = 1'b1;
            end else begin
              state_d = BURST;
              cnt_d   = 5'd1;
            end
          end else if (sel_f) begin
            f_gnt     = 1'b1;
            bram_en   = 1'b1;
            bram_addr = f_addr;
            f_tag_d   = 1'b1;
          end else begin
            bram_en = 1'b0;
          end
        end
        BURST: begin
          bram_en   = 1'b1;
          bram_addr = base_q + AW'(cnt_q);
          op_tag_d  = 1'b1;
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == (len_q - 5'd1)) begin
            last_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = 5'd0;
          end else begin
            state_d = BURST;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end
      endcase
    end
  end

  // state, burst context, read-return tags and read data capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= 5'd0;
      cnt_q    <= 5'd0;
      f_tag_q  <= 1'b0;
      op_tag_q <= 1'b0;
      last_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      f_tag_q  <= f_tag_d;
      op_tag_q <= op_tag_d;
      last_q   <= last_d;
      rdata_q  <= bram_dout;
    end
  end

  assign f_rvalid  = f_tag_q;
  assign op_rvalid = op_tag_q;
  assign op_last   = last_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q == BURST);

endmodule
